// File: rtl/regfile_2r1w_sb.sv
// rtl/regfile_2r1w_sb.sv - decode-stage register file, one write port, two read ports, busy scoreboard
//
// Parameters:
//   DATA_W   register width in bits
//   ADDR_W   address width, depth = 2**ADDR_W
//   BYPASS   1 = same-edge write data forwarded to a matching read
//   ZERO_REG 1 = register 0 reads zero, ignores writes, never busy
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   write_enable/addr/data         writeback port, also clears the scoreboard bit
//   rd_en                          capture new read results (0 = hold outputs)
//   read_addr_a/b                  source registers
//   read_data_a/b                  registered operand data
//   busy_a/b                       registered busy flag of each source
//   issue_en/issue_addr            mark a destination register busy
//   busy_vec                       live scoreboard, bit i = register i busy

module regfile_2r1w_sb #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 write_enable,
    input  logic [ADDR_W-1:0]    write_addr,
    input  logic [DATA_W-1:0]    write_data,
    input  logic                 rd_en,
    input  logic [ADDR_W-1:0]    read_addr_a,
    input  logic [ADDR_W-1:0]    read_addr_b,
    output logic [DATA_W-1:0]    read_data_a,
    output logic [DATA_W-1:0]    read_data_b,
    output logic                 busy_a,
    output logic                 busy_b,
    input  logic                 issue_en,
    input  logic [ADDR_W-1:0]    issue_addr,
    output logic [2**ADDR_W-1:0] busy_vec
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_nxt;

    logic wr_ok;
    logic zero_a;
    logic zero_b;
    logic fwd_a;
    logic fwd_b;
    logic [DATA_W-1:0] rdata_a_nxt;
    logic [DATA_W-1:0] rdata_b_nxt;

    // Writes to the hardwired zero register are dropped entirely.
    assign wr_ok  = write_enable && !(ZERO_REG && (write_addr == '0));

    assign zero_a = ZERO_REG && (read_addr_a == '0);
    assign zero_b = ZERO_REG && (read_addr_b == '0);

    assign fwd_a  = BYPASS && wr_ok && (write_addr == read_addr_a);
    assign fwd_b  = BYPASS && wr_ok && (write_addr == read_addr_b);

    // Zero register wins over forwarding; forwarding wins over the array.
    always_comb begin
        rdata_a_nxt = mem[read_addr_a];
        if (zero_a) begin
            rdata_a_nxt = '0;
        end else if (fwd_a) begin
            rdata_a_nxt = write_data;
        end
    end

    always_comb begin
        rdata_b_nxt = mem[read_addr_b];
        if (zero_b) begin
            rdata_b_nxt = '0;
        end else if (fwd_b) begin
            rdata_b_nxt = write_data;
        end
    end

    // Clear by writeback first, then set by issue, so a same-edge issue
    // to the register being written leaves it busy for the new producer.
    always_comb begin
        busy_nxt = busy_q;
        if (write_enable) begin
            busy_nxt[write_addr] = 1'b0;
        end
        if (issue_en) begin
            busy_nxt[issue_addr] = 1'b1;
        end
        if (ZERO_REG) begin
            busy_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[write_addr] <= write_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_nxt;
        end
    end

    // busy_x samples the post-edge scoreboard so a forwarded read is not
    // reported busy unless the same register is re-issued on that edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data_a <= '0;
            read_data_b <= '0;
            busy_a      <= 1'b0;
            busy_b      <= 1'b0;
        end else if (rd_en) begin
            read_data_a <= rdata_a_nxt;
            read_data_b <= rdata_b_nxt;
            busy_a      <= busy_nxt[read_addr_a];
            busy_b      <= busy_nxt[read_addr_b];
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// tb/tb_regfile_2r1w_sb.sv - scoreboard bench for regfile_2r1w_sb, bypass and zero-register variants

module tb_regfile_2r1w_sb;

    logic        clk;
    logic        rst;
    logic        write_enable;
    logic [2:0]  write_addr;
    logic [15:0] write_data;
    logic        rd_en;
    logic [2:0]  read_addr_a;
    logic [2:0]  read_addr_b;
    logic        issue_en;
    logic [2:0]  issue_addr;

    logic [15:0] rda0, rdb0, rda1, rdb1;
    logic        ba0, bb0, ba1, bb1;
    logic [7:0]  bv0, bv1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          row;
        logic [15:0] a0, b0;
        logic        ba0, bb0;
        logic [7:0]  v0;
        logic [15:0] a1, b1;
        logic        ba1, bb1;
        logic [7:0]  v1;
    } exp_t;

    exp_t exp_q [$];

    // dut0: forwarding, normal r0; dut1: no forwarding, hardwired r0
    regfile_2r1w_sb #(.DATA_W(16), .ADDR_W(3), .BYPASS(1'b1), .ZERO_REG(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
        .rd_en(rd_en), .read_addr_a(read_addr_a), .read_addr_b(read_addr_b),
        .read_data_a(rda0), .read_data_b(rdb0), .busy_a(ba0), .busy_b(bb0),
        .issue_en(issue_en), .issue_addr(issue_addr), .busy_vec(bv0)
    );

    regfile_2r1w_sb #(.DATA_W(16), .ADDR_W(3), .BYPASS(1'b0), .ZERO_REG(1'b1)) dut1 (
        .clk(clk), .rst(rst),
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
        .rd_en(rd_en), .read_addr_a(read_addr_a), .read_addr_b(read_addr_b),
        .read_data_a(rda1), .read_data_b(rdb1), .busy_a(ba1), .busy_b(bb1),
        .issue_en(issue_en), .issue_addr(issue_addr), .busy_vec(bv1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row=%0d got=%h expected=%h", name, row, act, exp);
        end
    endtask

    // Monitor: outputs are updated on every edge, compared on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("d0_read_data_a", e.row, {16'h0, rda0}, {16'h0, e.a0});
            chk("d0_read_data_b", e.row, {16'h0, rdb0}, {16'h0, e.b0});
            chk("d0_busy_a",      e.row, {31'h0, ba0},  {31'h0, e.ba0});
            chk("d0_busy_b",      e.row, {31'h0, bb0},  {31'h0, e.bb0});
            chk("d0_busy_vec",    e.row, {24'h0, bv0},  {24'h0, e.v0});
            chk("d1_read_data_a", e.row, {16'h0, rda1}, {16'h0, e.a1});
            chk("d1_read_data_b", e.row, {16'h0, rdb1}, {16'h0, e.b1});
            chk("d1_busy_a",      e.row, {31'h0, ba1},  {31'h0, e.ba1});
            chk("d1_busy_b",      e.row, {31'h0, bb1},  {31'h0, e.bb1});
            chk("d1_busy_vec",    e.row, {24'h0, bv1},  {24'h0, e.v1});
        end
    end

    int row_n = 0;

    task automatic row(
        input logic we, input logic [2:0] wa, input logic [15:0] wd,
        input logic re, input logic [2:0] ra, input logic [2:0] rb,
        input logic ie, input logic [2:0] ia,
        input logic [15:0] a0, input logic [15:0] b0, input logic xba0, input logic xbb0, input logic [7:0] v0,
        input logic [15:0] a1, input logic [15:0] b1, input logic xba1, input logic xbb1, input logic [7:0] v1);
        exp_t e;
        write_enable = we; write_addr = wa; write_data = wd;
        rd_en = re; read_addr_a = ra; read_addr_b = rb;
        issue_en = ie; issue_addr = ia;
        @(posedge clk);
        #1;
        row_n++;
        e.row = row_n;
        e.a0 = a0; e.b0 = b0; e.ba0 = xba0; e.bb0 = xbb0; e.v0 = v0;
        e.a1 = a1; e.b1 = b1; e.ba1 = xba1; e.bb1 = xbb1; e.v1 = v1;
        exp_q.push_back(e);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_d0_rda"}, row_n, {16'h0, rda0}, 32'h0);
        chk({tag, "_d0_rdb"}, row_n, {16'h0, rdb0}, 32'h0);
        chk({tag, "_d0_busy"}, row_n, {30'h0, ba0, bb0}, 32'h0);
        chk({tag, "_d0_vec"}, row_n, {24'h0, bv0}, 32'h0);
        chk({tag, "_d1_rda"}, row_n, {16'h0, rda1}, 32'h0);
        chk({tag, "_d1_rdb"}, row_n, {16'h0, rdb1}, 32'h0);
        chk({tag, "_d1_busy"}, row_n, {30'h0, ba1, bb1}, 32'h0);
        chk({tag, "_d1_vec"}, row_n, {24'h0, bv1}, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        write_enable = 1'b0; write_addr = '0; write_data = '0;
        rd_en = 1'b0; read_addr_a = '0; read_addr_b = '0;
        issue_en = 1'b0; issue_addr = '0;
        #2;
        chk_cleared("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // write / read
        row(1, 1, 16'hF0F0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 8'h00, 16'h0000, 16'h0000, 0, 0, 8'h00);
        row(1, 2, 16'h0F0F, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 8'h00, 16'h0000, 16'h0000, 0, 0, 8'h00);
        row(0, 0, 16'h0000, 1, 1, 2, 0, 0, 16'hF0F0, 16'h0F0F, 0, 0, 8'h00, 16'hF0F0, 16'h0F0F, 0, 0, 8'h00);
        // bypass: both ports on r3 during the write
        row(1, 3, 16'h1234, 1, 3, 3, 0, 0, 16'h1234, 16'h1234, 0, 0, 8'h00, 16'h0000, 16'h0000, 0, 0, 8'h00);
        row(0, 0, 16'h0000, 1, 3, 3, 0, 0, 16'h1234, 16'h1234, 0, 0, 8'h00, 16'h1234, 16'h1234, 0, 0, 8'h00);
        // scoreboard
        row(0, 0, 16'h0000, 1, 1, 2, 1, 5, 16'hF0F0, 16'h0F0F, 0, 0, 8'h20, 16'hF0F0, 16'h0F0F, 0, 0, 8'h20);
        row(0, 0, 16'h0000, 1, 5, 5, 0, 0, 16'h0000, 16'h0000, 1, 1, 8'h20, 16'h0000, 16'h0000, 1, 1, 8'h20);
        row(1, 5, 16'hAAAA, 1, 5, 1, 0, 0, 16'hAAAA, 16'hF0F0, 0, 0, 8'h00, 16'h0000, 16'hF0F0, 0, 0, 8'h00);
        row(1, 5, 16'hBBBB, 1, 5, 5, 1, 5, 16'hBBBB, 16'hBBBB, 1, 1, 8'h20, 16'hAAAA, 16'hAAAA, 1, 1, 8'h20);
        // hold with rd_en=0
        row(1, 1, 16'h5555, 0, 1, 2, 0, 0, 16'hBBBB, 16'hBBBB, 1, 1, 8'h20, 16'hAAAA, 16'hAAAA, 1, 1, 8'h20);
        row(0, 0, 16'h0000, 0, 1, 2, 1, 6, 16'hBBBB, 16'hBBBB, 1, 1, 8'h60, 16'hAAAA, 16'hAAAA, 1, 1, 8'h60);
        row(0, 0, 16'h0000, 1, 1, 6, 0, 0, 16'h5555, 16'h0000, 0, 1, 8'h60, 16'h5555, 16'h0000, 0, 1, 8'h60);
        // register 0: write + issue + bypass read
        row(1, 0, 16'hFFFF, 1, 0, 0, 1, 0, 16'hFFFF, 16'hFFFF, 1, 1, 8'h61, 16'h0000, 16'h0000, 0, 0, 8'h60);
        row(0, 0, 16'h0000, 1, 0, 7, 0, 0, 16'hFFFF, 16'h0000, 1, 0, 8'h61, 16'h0000, 16'h0000, 0, 0, 8'h60);
        row(1, 6, 16'h0606, 1, 6, 0, 0, 0, 16'h0606, 16'hFFFF, 0, 1, 8'h21, 16'h0000, 16'h0000, 0, 0, 8'h20);
        row(1, 1, 16'hF0F0, 1, 1, 5, 0, 0, 16'hF0F0, 16'hBBBB, 0, 1, 8'h21, 16'h5555, 16'hBBBB, 0, 1, 8'h20);

        // asynchronous reset between edges, held across an edge with a write and issue pending
        @(negedge clk);
        #1 rst = 1'b1;
        #1 chk_cleared("async_rst");
        write_enable = 1'b1; write_addr = 3'd4; write_data = 16'h9999;
        issue_en = 1'b1; issue_addr = 3'd4;
        rd_en = 1'b1; read_addr_a = 3'd4; read_addr_b = 3'd1;
        @(posedge clk);
        #1 chk_cleared("rst_held");
        rst = 1'b0;

        row(0, 0, 16'h0000, 1, 1, 5, 0, 0, 16'h0000, 16'h0000, 0, 0, 8'h00, 16'h0000, 16'h0000, 0, 0, 8'h00);
        row(1, 2, 16'h7777, 1, 2, 2, 1, 2, 16'h7777, 16'h7777, 1, 1, 8'h04, 16'h0000, 16'h0000, 1, 1, 8'h04);
        write_enable = 1'b0; issue_en = 1'b0; rd_en = 1'b0;

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w_sb.md
Name: regfile_2r1w_sb

Overview:
- Parametrised successor to the decode-stage register file: one write port, two independent read ports, and a per-register busy scoreboard.
- Sits in the decode stage. Feeds operand A/B to the ID/EX pipeline register and busy flags to the hazard unit.
- The writeback stage drives the write port. Decode issue drives the scoreboard set port.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 3, address width; depth = 2**ADDR_W registers
BYPASS, 1, 1 = same-cycle write-to-read forwarding on both read ports; 0 = read returns pre-write contents
ZERO_REG, 0, 1 = register 0 always reads zero, ignores writes, never busy

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
write_enable  in  1  commit write_data to write_addr on this edge
write_addr  in  ADDR_W  write destination
write_data  in  DATA_W  write value
rd_en  in  1  capture new read results; 0 = hold read outputs
read_addr_a  in  ADDR_W  port A source register
read_addr_b  in  ADDR_W  port B source register
read_data_a  out  DATA_W  registered port A data
read_data_b  out  DATA_W  registered port B data
busy_a  out  1  registered: port A source has a pending producer
busy_b  out  1  registered: port B source has a pending producer
issue_en  in  1  mark issue_addr busy (instruction with destination issued)
issue_addr  in  ADDR_W  destination register of the issued instruction
busy_vec  out  2**ADDR_W  live scoreboard, bit i = register i busy

Behaviour:
Reset:
- rst=1 asynchronously clears all registers, the scoreboard, read_data_a/b, busy_a/b and busy_vec to 0.
- rst asserted mid-operation discards any in-flight write or issue of that cycle.
- State stays cleared while rst is held; the first edge after deassertion operates normally.

Write:
- On a rising edge with write_enable=1, mem[write_addr] <= write_data.
- ZERO_REG=1 and write_addr=0: write is ignored.

Read:
- Synchronous, 1-cycle latency.
- On a rising edge with rd_en=1, read_data_x <= mem[read_addr_x].
- With rd_en=0, read_data_x and busy_x hold their values.

Bypass:
- Applies when BYPASS=1, write_enable=1, write_addr==read_addr_x and rd_en=1 on the same edge.
- read_data_x <= write_data, i.e. the new value.
- With BYPASS=0, the same case yields the old contents.
- ZERO_REG=1 with address 0 always returns 0 regardless of bypass.
- Ports A and B evaluate independently; both may target the same address.

Scoreboard:
- busy[i] is set on an edge with issue_en=1 and issue_addr=i.
- busy[i] is cleared on an edge with write_enable=1 and write_addr=i.
- Set and clear on the same address in the same cycle: set wins, because the new producer is outstanding.
- A write to a non-busy register is legal; busy stays 0.
- An issue to an already-busy register is legal; busy stays 1.
- ZERO_REG=1: bit 0 forced 0.

busy_a/busy_b:
- Captured with rd_en=1 from the next-state scoreboard, i.e. after the same-edge set/clear.
- Consistent with bypass: a read that forwards the writeback value does not report busy, unless the same register is re-issued that cycle.

busy_vec:
- Registered scoreboard state, with no extra latency.

Arithmetic:
- Widths come from the parameters only.
- No address range check is needed, because every address maps to a register.

Test Plan:
1. Write/read: write 16'hF0F0 to r1 and 16'h0F0F to r2 on consecutive edges, then read A=r1, B=r2 with rd_en=1 -> next cycle read_data_a=F0F0, read_data_b=0F0F.
2. Bypass: on one edge write 16'h1234 to r3 and read A=r3, B=r3 -> read_data_a=read_data_b=1234 with BYPASS=1; previous r3 contents (0 after reset) with BYPASS=0.
3. Reset: load r1=F0F0, assert rst between edges -> read_data_a/b, busy_vec=0 immediately (no clock); after release, read r1 -> 0.
4. Scoreboard: issue r5 -> busy_vec[5]=1; read A=r5 -> busy_a=1; writeback r5=16'hAAAA -> busy_vec[5]=0. Same-edge writeback r5 plus issue r5 -> busy_vec[5]=1.
5. Hold: rd_en=0 while read addresses change and r1 is rewritten -> read_data_a/b and busy_a/b unchanged; rd_en=1 -> new values.
6. ZERO_REG=1: write 16'hFFFF to r0 and issue r0 -> read r0 gives 0, busy_vec[0]=0, including the bypass case.
